// File: rtl/can_pkg.sv
// Shared constants and types for the CAN controller receive path.
// Receive FIFO: 64-byte circular buffer, frames of 3..13 bytes.
package can_pkg;

  localparam int FIFO_DEPTH    = 64;
  localparam int FRAME_LEN_MAX = 13;
  localparam int PTR_W         = 6;
  localparam int RMC_W         = 7;
  localparam int LEN_W         = 4;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [RMC_W-1:0] cnt_t;
  typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/can_rx_length_fifo.sv
// Frame-length FIFO: one 4-bit entry per committed frame.
// Head is combinational so a release can advance rbsa in one clk.
module can_rx_length_fifo
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  len_t push_len,
  input  logic pop,
  output len_t head,
  output cnt_t count
);

  len_t mem_q [FIFO_DEPTH];
  ptr_t wp_q, wp_d;
  ptr_t rp_q, rp_d;
  cnt_t cnt_q, cnt_d;
  logic do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push &&
              ((cnt_q != cnt_t'(FIFO_DEPTH)) || do_pop);
    wp_d  = wp_q + ptr_t'(do_push);
    rp_d  = rp_q + ptr_t'(do_pop);
    cnt_d = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    if (clear) begin
      do_push = 1'b0;
      wp_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= push_len;
  end

  assign head  = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/can_rx_fifo.sv
// SJA1000-style receive FIFO: frame RAM, RMC, RBSA, data overrun.
// CAN_RX_FIFO_DIRECT_ACCESS_EN adds an absolute RAM read window.
module can_rx_fifo
  import can_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reset_mode,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_commit,
  input  logic       wr_discard,
  input  logic       release_buffer,
  input  logic       clear_overrun,
  input  logic [3:0] rd_addr,
`ifdef CAN_RX_FIFO_DIRECT_ACCESS_EN
  input  logic       direct_en,
  input  logic [5:0] direct_addr,
`endif
  output logic [7:0] rd_data,
  output logic [6:0] rmc,
  output logic       rx_buffer_full,
  output logic       overrun,
  output logic       overrun_pulse,
  output logic [5:0] rbsa
);

  logic [7:0] ram_q [FIFO_DEPTH];

  ptr_t rbsa_q, rbsa_d;
  ptr_t wp_q, wp_d;
  ptr_t wpp_q, wpp_d;
  len_t plen_q, plen_d;
  cnt_t used_q, used_d;
  logic poison_q, poison_d;
  logic overrun_q, overrun_d;
  logic pulse_q, pulse_d;
  logic [7:0] rd_data_q, rd_data_d;

  cnt_t free_cnt;
  cnt_t rmc_cnt;
  len_t head_len;
  len_t plen_eff;
  ptr_t wpp_eff;
  ptr_t rd_ptr;
  logic poison_eff;
  logic wr_ok, drop, ram_we;
  logic commit_ok, rel_ok;

  can_rx_length_fifo u_len_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (reset_mode),
    .push     (commit_ok),
    .push_len (plen_eff),
    .pop      (rel_ok),
    .head     (head_len),
    .count    (rmc_cnt)
  );

  always_comb begin
    free_cnt = cnt_t'(FIFO_DEPTH) - used_q
             - cnt_t'(plen_q);
    wr_ok    = wr_en && (free_cnt != '0) &&
               (plen_q != len_t'(FRAME_LEN_MAX));
    drop     = wr_en && (free_cnt == '0) && !reset_mode;
    ram_we   = wr_ok && !reset_mode;
    plen_eff   = plen_q + len_t'(wr_ok);
    wpp_eff    = wpp_q + ptr_t'(wr_ok);
    // An over-long frame is poisoned but does not count as overrun.
    poison_eff = poison_q || (wr_en && !wr_ok);
    commit_ok  = wr_commit && !wr_discard && !poison_eff &&
                 (plen_eff != '0) && !reset_mode;
    rel_ok     = release_buffer && (rmc_cnt != '0) &&
                 !reset_mode;
  end

  always_comb begin
    rbsa_d    = rbsa_q;
    wp_d      = wp_q;
    wpp_d     = wpp_q;
    plen_d    = plen_q;
    used_d    = used_q;
    poison_d  = poison_q;
    overrun_d = overrun_q;
    pulse_d   = 1'b0;
    if (reset_mode) begin
      rbsa_d    = '0;
      wp_d      = '0;
      wpp_d     = '0;
      plen_d    = '0;
      used_d    = '0;
      poison_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      wpp_d    = wpp_eff;
      plen_d   = plen_eff;
      poison_d = poison_eff;
      if (wr_commit || wr_discard) begin
        wpp_d    = commit_ok ? wpp_eff : wp_q;
        plen_d   = '0;
        poison_d = 1'b0;
      end
      if (commit_ok) wp_d = wpp_eff;
      if (rel_ok) rbsa_d = rbsa_q + ptr_t'(head_len);
      used_d = used_q
             + (commit_ok ? cnt_t'(plen_eff) : '0)
             - (rel_ok ? cnt_t'(head_len) : '0);
      if (clear_overrun) overrun_d = 1'b0;
      if (drop) overrun_d = 1'b1;
      pulse_d = drop && !overrun_q;
    end
  end

`ifdef CAN_RX_FIFO_DIRECT_ACCESS_EN
  assign rd_ptr = direct_en ? direct_addr
                            : rbsa_q + ptr_t'(rd_addr);
`else
  assign rd_ptr = rbsa_q + ptr_t'(rd_addr);
`endif

  assign rd_data_d = ram_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[wpp_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbsa_q    <= '0;
      wp_q      <= '0;
      wpp_q     <= '0;
      plen_q    <= '0;
      used_q    <= '0;
      poison_q  <= 1'b0;
      overrun_q <= 1'b0;
      pulse_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rbsa_q    <= rbsa_d;
      wp_q      <= wp_d;
      wpp_q     <= wpp_d;
      plen_q    <= plen_d;
      used_q    <= used_d;
      poison_q  <= poison_d;
      overrun_q <= overrun_d;
      pulse_q   <= pulse_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign rmc            = rmc_cnt;
  assign rx_buffer_full = (rmc_cnt != '0);
  assign overrun        = overrun_q;
  assign overrun_pulse  = pulse_q;
  assign rbsa           = rbsa_q;

endmodule

// File: tb/tb_can_rx_fifo.sv
// Bench for can_rx_fifo: directed table, corner sequences, random run.
// A frame-queue model checks every cycle.
module tb_can_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reset_mode = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_commit = 1'b0;
  logic       wr_discard = 1'b0;
  logic       release_buffer = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [6:0] rmc;
  logic       rx_buffer_full;
  logic       overrun;
  logic       overrun_pulse;
  logic [5:0] rbsa;
`ifdef CAN_RX_FIFO_DIRECT_ACCESS_EN
  logic       direct_en = 1'b0;
  logic [5:0] direct_addr = '0;
`endif

  can_rx_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reset_mode     (reset_mode),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_commit      (wr_commit),
    .wr_discard     (wr_discard),
    .release_buffer (release_buffer),
    .clear_overrun  (clear_overrun),
    .rd_addr        (rd_addr),
`ifdef CAN_RX_FIFO_DIRECT_ACCESS_EN
    .direct_en      (direct_en),
    .direct_addr    (direct_addr),
`endif
    .rd_data        (rd_data),
    .rmc            (rmc),
    .rx_buffer_full (rx_buffer_full),
    .overrun        (overrun),
    .overrun_pulse  (overrun_pulse),
    .rbsa           (rbsa)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: list of committed frame lengths plus a byte image.
  logic [7:0] mem_m [64];
  bit         valid_m [64];
  int         frames[$];
  int m_rbsa = 0, m_wp = 0, m_pend = 0;
  bit m_poison = 0, m_ovr = 0, m_pulse = 0;
  bit m_rd_ok = 0;
  logic [7:0] m_rd = '0;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       cm;
    logic       dc;
    logic       rl;
    logic [3:0] ra;
    int         e_rmc;
    int         e_rbsa;
    int         e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic void add(input logic we, input int d,
                              input logic cm, input logic dc,
                              input logic rl, input int ra,
                              input int e_rmc, input int e_rbsa,
                              input int e_rd);
    vec_t v;
    v.we = we; v.d = d[7:0]; v.cm = cm; v.dc = dc;
    v.rl = rl; v.ra = ra[3:0];
    v.e_rmc = e_rmc; v.e_rbsa = e_rbsa; v.e_rd = e_rd;
    tbl.push_back(v);
  endfunction

  function automatic void model_update();
    int rp, used, free_b;
    bit drop;
    rp = (m_rbsa + int'(rd_addr)) % 64;
    m_rd_ok = valid_m[rp];
    m_rd = mem_m[rp];
    if (reset_mode) begin
      frames.delete();
      m_rbsa = 0; m_wp = 0; m_pend = 0;
      m_poison = 0; m_ovr = 0; m_pulse = 0;
      return;
    end
    used = 0;
    foreach (frames[i]) used += frames[i];
    free_b = 64 - used - m_pend;
    drop = 0;
    if (wr_en) begin
      if (free_b > 0) begin
        mem_m[(m_wp + m_pend) % 64] = wr_data;
        valid_m[(m_wp + m_pend) % 64] = 1;
        m_pend++;
      end else begin
        m_poison = 1;
        drop = 1;
      end
    end
    m_pulse = drop && !m_ovr;
    if (clear_overrun) m_ovr = 0;
    if (drop) m_ovr = 1;
    if (release_buffer && frames.size() > 0) begin
      m_rbsa = (m_rbsa + frames[0]) % 64;
      void'(frames.pop_front());
    end
    if (wr_commit) begin
      if (!m_poison && m_pend > 0) begin
        frames.push_back(m_pend);
        m_wp = (m_wp + m_pend) % 64;
      end
      m_pend = 0; m_poison = 0;
    end
    if (wr_discard) begin
      m_pend = 0; m_poison = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("rmc", rmc, frames.size());
    chk("rbsa", rbsa, m_rbsa);
    chk("rx_buffer_full", rx_buffer_full, frames.size() != 0);
    chk("overrun", overrun, m_ovr);
    chk("overrun_pulse", overrun_pulse, m_pulse);
    if (m_rd_ok) chk("rd_data", rd_data, m_rd);
  endtask

  task automatic op(input logic we, input logic [7:0] d,
                    input logic cm, input logic dc,
                    input logic rl, input logic co,
                    input logic rm, input logic [3:0] ra);
    wr_en = we; wr_data = d; wr_commit = cm; wr_discard = dc;
    release_buffer = rl; clear_overrun = co;
    reset_mode = rm; rd_addr = ra;
    step();
    wr_en = 0; wr_commit = 0; wr_discard = 0;
    release_buffer = 0; clear_overrun = 0; reset_mode = 0;
  endtask

  task automatic wr(input logic [7:0] d);
    op(1, d, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic commit();
    op(0, 8'h00, 1, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic rel();
    op(0, 8'h00, 0, 0, 1, 0, 0, 4'd0);
  endtask

  task automatic rmode();
    op(0, 8'h00, 0, 0, 0, 0, 1, 4'd0);
  endtask

  initial begin
    int pulses;
    // Directed table: write/commit/read/release/discard.
    for (int i = 0; i < 13; i++)
      add(1, (i == 0) ? 8'h88 : i, 0, 0, 0, 0, 0, 0, -1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 8'h88);
    add(0, 0, 0, 0, 0, 12, 1, 0, 8'h0C);
    add(0, 0, 0, 0, 1, 0, 0, 13, 8'h88);
    add(0, 0, 0, 0, 1, 0, 0, 13, -1);
    for (int i = 0; i < 5; i++)
      add(1, 8'h55, 0, 0, 0, 0, 0, 13, -1);
    add(0, 0, 0, 1, 0, 0, 0, 13, -1);
    for (int i = 0; i < 3; i++)
      add(1, 8'hA0 + i, 0, 0, 0, 0, 0, 13, -1);
    add(0, 0, 1, 0, 0, 0, 1, 13, 8'hA0);
    add(0, 0, 0, 0, 0, 1, 1, 13, 8'hA1);
    add(0, 0, 0, 0, 0, 2, 1, 13, 8'hA2);

    #1;
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset rmc", rmc, 7'd0);
    chk("reset rbsa", rbsa, 6'd0);
    chk("reset rx_buffer_full", rx_buffer_full, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    chk("reset overrun_pulse", overrun_pulse, 1'b0);
    #11 rst_n = 1'b1;

    foreach (tbl[i]) begin
      op(tbl[i].we, tbl[i].d, tbl[i].cm, tbl[i].dc,
         tbl[i].rl, 0, 0, tbl[i].ra);
      chk("vec rmc", rmc, tbl[i].e_rmc);
      chk("vec rbsa", rbsa, tbl[i].e_rbsa);
      chk("vec full", rx_buffer_full, tbl[i].e_rmc != 0);
      if (tbl[i].e_rd >= 0)
        chk("vec rd_data", rd_data, tbl[i].e_rd);
    end

    // Overrun: fifth 13-byte frame loses its last byte.
    rmode();
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 13; b++) wr(8'h10 * f + b);
      commit();
    end
    chk("ovr rmc4", rmc, 7'd4);
    pulses = 0;
    for (int b = 0; b < 13; b++) begin
      wr(8'hE0 + b);
      pulses += int'(overrun_pulse);
    end
    chk("ovr flag", overrun, 1'b1);
    commit();
    pulses += int'(overrun_pulse);
    chk("ovr pulses", pulses, 1);
    chk("ovr rmc after poisoned commit", rmc, 7'd4);
    op(0, 8'h00, 0, 0, 0, 1, 0, 4'd0);
    chk("ovr cleared", overrun, 1'b0);

    // Wrap: advance rbsa to 60 then straddle the end.
    rmode();
    for (int f = 0; f < 12; f++) begin
      for (int b = 0; b < 5; b++) wr(8'h20 + b);
      commit();
      rel();
    end
    chk("wrap rbsa60", rbsa, 6'd60);
    for (int b = 0; b < 8; b++) wr(8'hC0 + b);
    commit();
    chk("wrap rmc1", rmc, 7'd1);
    for (int k = 0; k < 8; k++) begin
      op(0, 8'h00, 0, 0, 0, 0, 0, 4'(k));
      chk("wrap rd_data", rd_data, 8'hC0 + k);
    end
    rel();
    chk("wrap rbsa after", rbsa, 6'd4);

    // Commit + release together; reset_mode mid-frame.
    rmode();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) wr(8'h30 + b);
      commit();
    end
    for (int b = 0; b < 3; b++) wr(8'h40 + b);
    op(0, 8'h00, 1, 0, 1, 0, 0, 4'd0);
    chk("cr rmc2", rmc, 7'd2);
    chk("cr rbsa3", rbsa, 6'd3);
    wr(8'h77);
    wr(8'h78);
    rmode();
    chk("rm rmc0", rmc, 7'd0);
    chk("rm rbsa0", rbsa, 6'd0);
    for (int b = 0; b < 3; b++) wr(8'hD0 + b);
    commit();
    op(0, 8'h00, 0, 0, 0, 0, 0, 4'd0);
    chk("rm frame byte0", rd_data, 8'hD0);
    op(0, 8'h00, 0, 0, 0, 0, 0, 4'd2);
    chk("rm frame byte2", rd_data, 8'hD2);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic we, cm, dc, rl, co, rm;
      int r;
      r  = $urandom_range(0, 99);
      we = (m_pend < 13) && (r < 65);
      cm = (m_pend >= 3) && ($urandom_range(0, 99) < 25);
      dc = !cm && ($urandom_range(0, 99) < 3);
      rl = $urandom_range(0, 99) < 9;
      co = $urandom_range(0, 99) < 5;
      rm = $urandom_range(0, 999) < 4;
      op(we, 8'($urandom), cm, dc, rl, co, rm,
         4'($urandom_range(0, 12)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
